game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Top-level game sequencer for N-tank matches; successor to the single-round title/new-round/in-game controller.
- Adds the following on top of round sequencing:
  - parametrised player count;
  - per-player score registers with a first-to-WIN_SCORE match end;
  - a frame-timed round-end delay so trailing bullets resolve;
  - edge-detected start and pause keys.
- Sits between the USB keycode path, tank/bullet collision logic, maze generator and the renderer.

Parameters:
- NUM_PLAYERS, 2, number of tanks; legal range 2..4.
- SCORE_W, 4, width of each score counter.
- WIN_SCORE, 5, score that ends the match; must be at most 2^SCORE_W-1.
- END_DELAY, 120, frame_tick pulses spent in ROUND_END; must be at least 1.
- START_KEY, 8'h28, HID code for start/continue (Enter).
- PAUSE_KEY, 8'h13, HID code for pause toggle (P).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  reset, synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- keycode  in  32  four HID key bytes.
- maze_ready  in  1  maze generator done (level).
- hit  in  NUM_PLAYERS  hit[i]=1: tank i destroyed this cycle.
- title  out  1  high in TITLE.
- game_end  out  2  01 in NEW_ROUND, 10 in GAME_OVER, 00 otherwise.
- maze_start  out  1  one-cycle pulse requesting a new maze.
- round_active  out  1  high in IN_GAME only; gates tank/bullet motion.
- paused  out  1  high in PAUSED.
- alive  out  NUM_PLAYERS  registered alive mask.
- scores  out  NUM_PLAYERS*SCORE_W  player i at [i*SCORE_W +: SCORE_W].
- match_winner  out  2  index of match winner; valid in GAME_OVER.

Behaviour:

Reset values:
- State=TITLE; scores=0; alive=all ones; delay counter=0; match_winner=0; key-edge registers=0.
- Resulting outputs: title=1, all other outputs 0, except alive, which resets to all ones.

Key detection:
- start_hit = any of the 4 keycode bytes == START_KEY; pause_hit likewise for PAUSE_KEY.
- Both are registered each cycle. start_edge = start_hit & ~start_hit_q, and pause_edge likewise.
- A held key produces exactly one edge.

State machine (registered state; outputs decoded from state except scores, alive and match_winner, which are registered):
- TITLE:
  - On start_edge -> NEW_ROUND.
  - On the same cycle, clear scores to 0.
- NEW_ROUND:
  - On entry, maze_start=1 for exactly one cycle and alive=all ones.
  - maze_ready is ignored on the entry cycle.
  - maze_ready=1 on any later cycle -> IN_GAME.
- IN_GAME:
  - Each cycle, alive <= alive & ~hit.
  - If popcount(alive & ~hit) <= 1 -> ROUND_END and clear the delay counter.
  - Else if pause_edge -> PAUSED.
  - If hit and pause_edge occur in the same cycle, the hit applies and the pause is dropped when the round ends; otherwise the pause is taken with the hit still applied.
- PAUSED:
  - hit is ignored and alive is held.
  - pause_edge -> IN_GAME.
  - start_edge is ignored.
- ROUND_END:
  - hit still clears alive bits, so simultaneous or trailing kills can produce a draw.
  - Counter increments on frame_tick; when it reaches END_DELAY-1 and frame_tick=1 -> SCORE.
- SCORE (exactly one cycle):
  - If popcount(alive)==1, the survivor's score increments.
  - If popcount(alive)==0 (draw), no score changes.
  - If the incremented score == WIN_SCORE -> GAME_OVER and match_winner <= survivor index.
  - Else -> NEW_ROUND.
- GAME_OVER:
  - Scores and match_winner are held.
  - start_edge -> TITLE.
  - Scores stay visible until the next TITLE start.

Additional rules:
- Score increments never overflow, because WIN_SCORE <= max value.
- hit bits for players with alive=0 have no effect.
- RESET asserted in any state, including mid-ROUND_END or PAUSED, returns to the reset values on the next edge; maze_start is not pulsed.
- frame_tick has no effect outside ROUND_END.

Test Plan:
1. Reset, then hold keycode=32'h00000028 for 10 cycles -> exactly one maze_start pulse; state stays NEW_ROUND until maze_ready=1; title=0 and game_end=01 meanwhile.
2. Defaults, IN_GAME, hit=2'b10 -> next cycle alive=01, round_active=0. After exactly 120 frame_ticks, one SCORE cycle -> scores[3:0]=1, scores[7:4]=0, then NEW_ROUND with maze_start pulse and alive=11.
3. IN_GAME, hit=2'b01, then hit=2'b10 during ROUND_END tick 50 -> alive=00 at SCORE, both scores unchanged, next state NEW_ROUND.
4. Player 1 wins 5 rounds -> after the fifth SCORE, game_end=10, match_winner=1, scores[7:4]=5. A start_edge then gives title=1; a second start_edge clears scores to 0.
5. IN_GAME, keycode byte2=8'h13 -> paused=1, round_active=0. hit=2'b01 while paused -> alive stays 11. Release and re-press P -> round_active=1.
6. NUM_PLAYERS=3: hits on players 0 then 2 in separate cycles -> ROUND_END only after the second hit, with alive=3'b010. RESET asserted at delay count 60 -> title=1, scores=0, alive=111.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - N-tank match sequencer: rounds, pause, round-end delay, scoring
//
// Ports:
//   CLK, RESET    clock, synchronous active-high reset
//   frame_tick    one-cycle pulse per video frame (only counted in ROUND_END)
//   keycode       four HID key bytes; START_KEY / PAUSE_KEY are edge-detected
//   maze_ready    maze generator done (level)
//   hit           per-tank destroyed strobe
//   title         high in TITLE
//   game_end      01 in NEW_ROUND, 10 in GAME_OVER, 00 otherwise
//   maze_start    one-cycle pulse on entry to NEW_ROUND
//   round_active  high in IN_GAME only
//   paused        high in PAUSED
//   alive         registered alive mask
//   scores        packed per-player scores, player i at [i*SCORE_W +: SCORE_W]
//   match_winner  winning player index, valid in GAME_OVER
module game_flow_ctrl #(
  parameter int         NUM_PLAYERS = 2,
  parameter int         SCORE_W     = 4,
  parameter int         WIN_SCORE   = 5,
  parameter int         END_DELAY   = 120,
  parameter logic [7:0] START_KEY   = 8'h28,
  parameter logic [7:0] PAUSE_KEY   = 8'h13
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           frame_tick,
  input  logic [31:0]                    keycode,
  input  logic                           maze_ready,
  input  logic [NUM_PLAYERS-1:0]         hit,
  output logic                           title,
  output logic [1:0]                     game_end,
  output logic                           maze_start,
  output logic                           round_active,
  output logic                           paused,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic [1:0]                     match_winner
);

  localparam int CNT_W = (END_DELAY > 1) ? $clog2(END_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(END_DELAY - 1);

  typedef enum logic [2:0] {
    S_TITLE,
    S_NEW_ROUND,
    S_IN_GAME,
    S_PAUSED,
    S_ROUND_END,
    S_SCORE,
    S_GAME_OVER
  } state_t;

  state_t                         state_q, state_d;
  logic                           start_hit, pause_hit;
  logic                           start_hit_q, pause_hit_q;
  logic                           start_edge, pause_edge;
  logic                           entry_q;
  logic [NUM_PLAYERS-1:0]         alive_q, alive_hit;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores_q;
  logic [1:0]                     winner_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [1:0]                     surv_idx;
  logic [SCORE_W-1:0]             surv_score, score_next;
  logic                           one_left, win;

  function automatic logic [2:0] count_ones(input logic [NUM_PLAYERS-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  always_comb begin
    start_hit = 1'b0;
    pause_hit = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (keycode[b*8 +: 8] == START_KEY) start_hit = 1'b1;
      if (keycode[b*8 +: 8] == PAUSE_KEY) pause_hit = 1'b1;
    end
  end

  assign start_edge = start_hit & ~start_hit_q;
  assign pause_edge = pause_hit & ~pause_hit_q;
  assign alive_hit  = alive_q & ~hit;

  // Survivor lookup is only meaningful when exactly one alive bit is set.
  always_comb begin
    surv_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (alive_q[i]) surv_idx = 2'(i);
    end
  end

  assign surv_score = scores_q[int'(surv_idx)*SCORE_W +: SCORE_W];
  assign score_next = surv_score + SCORE_W'(1);
  assign one_left   = (count_ones(alive_q) == 3'd1);
  assign win        = (score_next == SCORE_W'(WIN_SCORE));

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_TITLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_TITLE:     if (start_edge) state_d = S_NEW_ROUND;
      // entry_q marks the first NEW_ROUND cycle, where maze_ready is stale
      S_NEW_ROUND: if (!entry_q && maze_ready) state_d = S_IN_GAME;
      S_IN_GAME: begin
        if (count_ones(alive_hit) <= 3'd1) state_d = S_ROUND_END;
        else if (pause_edge)               state_d = S_PAUSED;
      end
      S_PAUSED:    if (pause_edge) state_d = S_IN_GAME;
      S_ROUND_END: if (frame_tick && cnt_q == CNT_LAST) state_d = S_SCORE;
      S_SCORE:     state_d = (one_left && win) ? S_GAME_OVER : S_NEW_ROUND;
      S_GAME_OVER: if (start_edge) state_d = S_TITLE;
      default:     state_d = S_TITLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      start_hit_q <= 1'b0;
      pause_hit_q <= 1'b0;
      entry_q     <= 1'b0;
      alive_q     <= '1;
      scores_q    <= '0;
      winner_q    <= '0;
      cnt_q       <= '0;
    end else begin
      start_hit_q <= start_hit;
      pause_hit_q <= pause_hit;
      entry_q     <= (state_d == S_NEW_ROUND) && (state_q != S_NEW_ROUND);

      if (state_d == S_NEW_ROUND && state_q != S_NEW_ROUND)
        alive_q <= '1;
      else if (state_q == S_IN_GAME || state_q == S_ROUND_END)
        alive_q <= alive_hit;

      if (state_q == S_TITLE && start_edge)
        scores_q <= '0;
      else if (state_q == S_SCORE && one_left) begin
        scores_q[int'(surv_idx)*SCORE_W +: SCORE_W] <= score_next;
        if (win) winner_q <= surv_idx;
      end

      // Held at zero through IN_GAME so ROUND_END always starts from a clean count.
      if (state_q == S_IN_GAME)
        cnt_q <= '0;
      else if (state_q == S_ROUND_END && frame_tick)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    title        = (state_q == S_TITLE);
    game_end     = 2'b00;
    if (state_q == S_NEW_ROUND) game_end = 2'b01;
    if (state_q == S_GAME_OVER) game_end = 2'b10;
    maze_start   = (state_q == S_NEW_ROUND) && entry_q;
    round_active = (state_q == S_IN_GAME);
    paused       = (state_q == S_PAUSED);
    alive        = alive_q;
    scores       = scores_q;
    match_winner = winner_q;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl
module tb_game_flow_ctrl;

  localparam logic [7:0] START = 8'h28;
  localparam logic [7:0] PKEY  = 8'h13;

  logic        CLK;
  logic        RESET, frame_tick, maze_ready;
  logic [31:0] keycode;
  logic [1:0]  hit;
  logic        title, maze_start, round_active, paused;
  logic [1:0]  game_end, alive, match_winner;
  logic [7:0]  scores;

  logic        RESET3, ft3, ready3;
  logic [31:0] key3;
  logic [2:0]  hit3;
  logic        title3, ms3, ra3, paused3;
  logic [1:0]  ge3, winner3;
  logic [2:0]  alive3;
  logic [11:0] scores3;

  int checks   = 0;
  int failures = 0;

  int sm[2];
  bit am[2];
  bit paused_m, key_prev;
  bit over;

  game_flow_ctrl dut (
    .CLK(CLK), .RESET(RESET), .frame_tick(frame_tick), .keycode(keycode),
    .maze_ready(maze_ready), .hit(hit), .title(title), .game_end(game_end),
    .maze_start(maze_start), .round_active(round_active), .paused(paused),
    .alive(alive), .scores(scores), .match_winner(match_winner)
  );

  game_flow_ctrl #(.NUM_PLAYERS(3)) dut3 (
    .CLK(CLK), .RESET(RESET3), .frame_tick(ft3), .keycode(key3),
    .maze_ready(ready3), .hit(hit3), .title(title3), .game_end(ge3),
    .maze_start(ms3), .round_active(ra3), .paused(paused3),
    .alive(alive3), .scores(scores3), .match_winner(winner3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int n_alive();
    return int'(am[0]) + int'(am[1]);
  endfunction

  function automatic logic [1:0] pack_alive();
    return {am[1], am[0]};
  endfunction

  function automatic logic [7:0] pack_scores();
    return {4'(sm[1]), 4'(sm[0])};
  endfunction

  typedef struct {
    logic [31:0] key;
    logic        ready;
    logic [1:0]  h;
    logic        ft;
    logic        ex_title;
    logic [1:0]  ex_ge;
    logic        ex_ms;
    logic        ex_ra;
    logic        ex_p;
    logic [1:0]  ex_alive;
  } vec_t;

  vec_t vt[17];

  // Starts in the first NEW_ROUND cycle; maze_ready there must be ignored.
  task automatic enter_game();
    int w;
    w = $urandom_range(1, 4);
    hit = 2'b00;
    frame_tick = 1'b0;
    keycode = 32'h0;
    for (int i = 0; i < w; i++) begin
      maze_ready = (i == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      check("nr_wait_game_end", game_end, 2'b01);
      check("nr_wait_maze_start", maze_start, 1'b0);
    end
    maze_ready = 1'b1;
    tick();
    maze_ready = 1'b0;
    check("nr_go_active", round_active, 1'b1);
    key_prev = 1'b0;
  endtask

  task automatic play_round(input bit rnd, input logic [1:0] kill, output bit done);
    logic [1:0] h;
    bit press, pedge, ft;
    int guard, ticks, s;
    done = 1'b0;
    guard = 0;
    paused_m = 1'b0;
    while (n_alive() > 1 && guard < 400) begin
      h = 2'b00;
      press = 1'b0;
      if (rnd) begin
        if ($urandom_range(0, 3) == 0) h = 2'($urandom_range(0, 3));
        press = ($urandom_range(0, 5) == 0);
      end else begin
        h = kill;
      end
      pedge = press && !key_prev;
      key_prev = press;
      keycode = press ? {24'h0, PKEY} : 32'h0;
      hit = h;
      frame_tick = 1'($urandom_range(0, 1));
      tick();
      if (paused_m) begin
        if (pedge) paused_m = 1'b0;
      end else begin
        for (int i = 0; i < 2; i++) if (h[i]) am[i] = 1'b0;
        if (n_alive() > 1 && pedge) paused_m = 1'b1;
      end
      guard++;
      check("ig_alive", alive, pack_alive());
      check("ig_paused", paused, paused_m);
      check("ig_active", round_active, (n_alive() > 1) && !paused_m);
    end
    if (guard >= 400) begin
      checks++;
      failures++;
      $display("FAIL ig_guard actual=%0d expected<400", guard);
    end
    keycode = 32'h0;
    key_prev = 1'b0;
    ticks = 0;
    while (ticks < 120) begin
      h = (rnd && $urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      ft = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      hit = h;
      frame_tick = ft;
      tick();
      for (int i = 0; i < 2; i++) if (h[i]) am[i] = 1'b0;
      ticks += int'(ft);
      check("re_alive", alive, pack_alive());
      check("re_game_end", game_end, 2'b00);
    end
    hit = 2'b00;
    frame_tick = 1'b0;
    check("sc_alive", alive, pack_alive());
    s = am[1] ? 1 : 0;
    if (n_alive() == 1) begin
      sm[s]++;
      done = (sm[s] == 5);
    end
    tick();
    check("sc_scores", scores, pack_scores());
    if (done) begin
      check("sc_game_over", game_end, 2'b10);
      check("sc_winner", match_winner, 2'(s));
    end else begin
      check("sc_new_round", game_end, 2'b01);
      check("sc_maze_start", maze_start, 1'b1);
      am[0] = 1'b1;
      am[1] = 1'b1;
      check("sc_alive_reset", alive, pack_alive());
    end
  endtask

  task automatic restart();
    keycode = {24'h0, START};
    tick();
    check("go_title", title, 1'b1);
    check("go_scores_kept", scores, pack_scores());
    keycode = 32'h0;
    tick();
    keycode = {24'h0, START};
    tick();
    keycode = 32'h0;
    sm[0] = 0;
    sm[1] = 0;
    am[0] = 1'b1;
    am[1] = 1'b1;
    check("go_scores_clr", scores, pack_scores());
    check("go_game_end", game_end, 2'b01);
    check("go_maze_start", maze_start, 1'b1);
  endtask

  initial begin
    RESET = 1'b1; frame_tick = 1'b0; maze_ready = 1'b0; keycode = 32'h0; hit = 2'b00;
    RESET3 = 1'b1; ft3 = 1'b0; ready3 = 1'b0; key3 = 32'h0; hit3 = 3'b000;
    sm[0] = 0; sm[1] = 0; am[0] = 1'b1; am[1] = 1'b1;
    paused_m = 1'b0; key_prev = 1'b0;

    //            key            rdy   hit    ft    title ge    ms    ra    p     alive
    vt[0]  = '{32'h0,        1'b0, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[1]  = '{32'h28,       1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 2'b11};
    vt[2]  = '{32'h28,       1'b1, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[3]  = '{32'h28,       1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[4]  = '{32'h28,       1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[5]  = '{32'h28,       1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[6]  = '{32'h28,       1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[7]  = '{32'h28,       1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[8]  = '{32'h28,       1'b0, 2'b00, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 2'b11};
    vt[9]  = '{32'h28,       1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11};
    vt[10] = '{32'h00130000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11};
    vt[11] = '{32'h00130000, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11};
    vt[12] = '{32'h0,        1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 2'b11};
    vt[13] = '{32'h13,       1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11};
    vt[14] = '{32'h13,       1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11};
    vt[15] = '{32'h28000000, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 2'b11};
    vt[16] = '{32'h0,        1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b01};

    tick();
    tick();
    check("rst_title", title, 1'b1);
    check("rst_game_end", game_end, 2'b00);
    check("rst_maze_start", maze_start, 1'b0);
    check("rst_active", round_active, 1'b0);
    check("rst_paused", paused, 1'b0);
    check("rst_alive", alive, 2'b11);
    check("rst_scores", scores, 8'h00);
    check("rst_winner", match_winner, 2'b00);
    RESET = 1'b0;
    RESET3 = 1'b0;

    for (int i = 0; i < 17; i++) begin
      keycode = vt[i].key;
      maze_ready = vt[i].ready;
      hit = vt[i].h;
      frame_tick = vt[i].ft;
      tick();
      check($sformatf("vec%0d_title", i), title, vt[i].ex_title);
      check($sformatf("vec%0d_game_end", i), game_end, vt[i].ex_ge);
      check($sformatf("vec%0d_maze_start", i), maze_start, vt[i].ex_ms);
      check($sformatf("vec%0d_active", i), round_active, vt[i].ex_ra);
      check($sformatf("vec%0d_paused", i), paused, vt[i].ex_p);
      check($sformatf("vec%0d_alive", i), alive, vt[i].ex_alive);
    end
    hit = 2'b00;

    // Round end delay counted with gaps between frame ticks: exactly 120 ticks.
    for (int t = 0; t < 120; t++) begin
      frame_tick = 1'b0;
      tick();
      check("t2_delay_game_end", game_end, 2'b00);
      frame_tick = 1'b1;
      tick();
    end
    frame_tick = 1'b0;
    check("t2_score_pending", scores, 8'h00);
    tick();
    check("t2_scores", scores, 8'h01);
    check("t2_new_round", game_end, 2'b01);
    check("t2_maze_start", maze_start, 1'b1);
    check("t2_alive", alive, 2'b11);
    sm[0] = 1;

    // Draw via a trailing kill; a pause edge on the ending cycle is dropped.
    enter_game();
    keycode = {24'h0, PKEY};
    hit = 2'b01;
    tick();
    keycode = 32'h0;
    check("t3_alive_first", alive, 2'b10);
    check("t3_pause_dropped", paused, 1'b0);
    check("t3_inactive", round_active, 1'b0);
    for (int i = 0; i < 120; i++) begin
      hit = (i == 49) ? 2'b10 : 2'b00;
      frame_tick = 1'b1;
      tick();
    end
    hit = 2'b00;
    frame_tick = 1'b0;
    check("t3_draw_alive", alive, 2'b00);
    tick();
    check("t3_scores", scores, 8'h01);
    check("t3_new_round", game_end, 2'b01);
    check("t3_alive_reset", alive, 2'b11);

    // Player 1 takes five straight rounds.
    enter_game();
    over = 1'b0;
    for (int r = 0; r < 5; r++) begin
      play_round(1'b0, 2'b01, over);
      if (!over) enter_game();
    end
    check("t4_over", over, 1'b1);
    check("t4_scores", scores, 8'h51);
    check("t4_winner", match_winner, 2'b01);
    check("t4_game_end", game_end, 2'b10);
    restart();

    for (int r = 0; r < 20; r++) begin
      enter_game();
      play_round(1'b1, 2'b00, over);
      if (over) restart();
    end

    // Three players: round ends only when one tank is left; reset mid-delay.
    key3 = {24'h0, START};
    tick();
    key3 = 32'h0;
    check("t6_maze_start", ms3, 1'b1);
    tick();
    ready3 = 1'b1;
    tick();
    ready3 = 1'b0;
    check("t6_active", ra3, 1'b1);
    hit3 = 3'b001;
    tick();
    hit3 = 3'b000;
    check("t6_alive_after_p0", alive3, 3'b110);
    check("t6_still_active", ra3, 1'b1);
    tick();
    hit3 = 3'b100;
    tick();
    hit3 = 3'b000;
    check("t6_alive_after_p2", alive3, 3'b010);
    check("t6_round_end", ra3, 1'b0);
    ft3 = 1'b1;
    repeat (60) tick();
    ft3 = 1'b0;
    check("t6_mid_delay_title", title3, 1'b0);
    check("t6_mid_delay_game_end", ge3, 2'b00);
    RESET3 = 1'b1;
    tick();
    check("t6_rst_title", title3, 1'b1);
    check("t6_rst_scores", scores3, 12'h000);
    check("t6_rst_alive", alive3, 3'b111);
    check("t6_rst_maze_start", ms3, 1'b0);
    check("t6_rst_game_end", ge3, 2'b00);
    RESET3 = 1'b0;
    tick();
    check("t6_post_title", title3, 1'b1);
    check("t6_post_maze_start", ms3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
